// File: rtl/ld_st_unit.sv
// Load/store sequencer: issues one data-memory access per Start, waits for MemReady with a
// bounded timeout, and writes load results back to the accumulator register.
module ld_st_unit #(
  parameter int unsigned W       = 8,
  parameter int unsigned D       = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start_i,
  input  logic         is_store_i,
  input  logic [W-1:0] ld_addr_i,
  input  logic [W-1:0] st_addr_i,
  input  logic [W-1:0] acc_in_i,
  output logic [W-1:0] mem_addr_o,
  output logic         mem_rd_en_o,
  output logic         mem_wr_en_o,
  output logic [W-1:0] mem_wr_data_o,
  input  logic [W-1:0] mem_rd_data_i,
  input  logic         mem_ready_i,
  output logic         rf_write_en_o,
  output logic [D-1:0] rf_waddr_o,
  output logic [W-1:0] rf_data_in_o,
  output logic         busy_o,
  output logic         done_o,
  output logic         err_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_WB,
    S_FIN
  } state_e;

  localparam logic [D-1:0] ACC_IDX  = '1;
  localparam logic [7:0]   CNT_LAST = 8'(TIMEOUT - 1);

  state_e       state_q, state_d;
  logic         op_q, op_d;          // 1 = store, 0 = load
  logic [W-1:0] addr_q, addr_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] rdata_q, rdata_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         err_q, err_d;

  // NOTE: every register gets a value on the asynchronous reset edge, and all sequential
  // updates use non-blocking assignments so each register sees the pre-edge value of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // NOTE: each signal written here is first given a hold/default value, so no path through
  // the case statement leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    data_d  = data_q;
    rdata_d = rdata_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = is_store_i;
          addr_d  = is_store_i ? st_addr_i : ld_addr_i;
          data_d  = acc_in_i;
          rdata_d = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_ready_i) begin
          if (op_q) begin
            state_d = S_FIN;
          end else begin
            rdata_d = mem_rd_data_i;
            state_d = S_WB;
          end
        end else if (cnt_q == CNT_LAST) begin
          // This cycle is the TIMEOUT-th one without an acknowledge.
          cnt_d   = cnt_q + 8'd1;
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WB: begin
        state_d = S_FIN;
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs decode from registered state only, so they are glitch-free and all zero in reset.
  always_comb begin
    busy_o        = (state_q != S_IDLE);
    mem_addr_o    = '0;
    mem_wr_data_o = '0;
    mem_rd_en_o   = 1'b0;
    mem_wr_en_o   = 1'b0;
    rf_write_en_o = 1'b0;
    rf_waddr_o    = '0;
    rf_data_in_o  = '0;
    done_o        = 1'b0;
    err_o         = 1'b0;

    if (state_q != S_IDLE) begin
      mem_addr_o    = addr_q;
      mem_wr_data_o = data_q;
    end

    unique case (state_q)
      S_REQ: begin
        mem_rd_en_o = ~op_q;
        mem_wr_en_o = op_q;
      end
      S_WB: begin
        rf_write_en_o = 1'b1;
        rf_waddr_o    = ACC_IDX;
        rf_data_in_o  = rdata_q;
      end
      S_FIN: begin
        done_o = ~err_q;
        err_o  = err_q;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_ld_st_unit.sv
// Directed bench for ld_st_unit: expected bus/writeback/status events are queued with their
// cycle number when stimulus is applied and matched as the DUT produces them.
module tb_ld_st_unit;

  localparam int W = 8;
  localparam int D = 4;

  localparam logic [2:0] K_RD   = 3'd1;
  localparam logic [2:0] K_WR   = 3'd2;
  localparam logic [2:0] K_RF   = 3'd3;
  localparam logic [2:0] K_DONE = 3'd4;
  localparam logic [2:0] K_ERR  = 3'd5;

  typedef struct packed {
    logic [2:0]  kind;
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         is_store;
  logic [W-1:0] ld_addr;
  logic [W-1:0] st_addr;
  logic [W-1:0] acc_in;
  logic [W-1:0] mem_addr;
  logic         mem_rd_en;
  logic         mem_wr_en;
  logic [W-1:0] mem_wr_data;
  logic [W-1:0] mem_rd_data;
  logic         mem_ready;
  logic         rf_write_en;
  logic [D-1:0] rf_waddr;
  logic [W-1:0] rf_data_in;
  logic         busy;
  logic         done;
  logic         err;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] cyc = '0;
  ev_t         exp_q[$];

  ld_st_unit #(.W(W), .D(D), .TIMEOUT(15)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_i       (start),
    .is_store_i    (is_store),
    .ld_addr_i     (ld_addr),
    .st_addr_i     (st_addr),
    .acc_in_i      (acc_in),
    .mem_addr_o    (mem_addr),
    .mem_rd_en_o   (mem_rd_en),
    .mem_wr_en_o   (mem_wr_en),
    .mem_wr_data_o (mem_wr_data),
    .mem_rd_data_i (mem_rd_data),
    .mem_ready_i   (mem_ready),
    .rf_write_en_o (rf_write_en),
    .rf_waddr_o    (rf_waddr),
    .rf_data_in_o  (rf_data_in),
    .busy_o        (busy),
    .done_o        (done),
    .err_o         (err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 32'd1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] addr, input logic [7:0] data,
                      input logic [31:0] at);
    ev_t e;
    e.kind = kind;
    e.addr = addr;
    e.data = data;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  task automatic next();
    @(negedge clk);
  endtask

  function automatic logic [33:0] all_outputs();
    return {mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, rf_write_en, rf_waddr, rf_data_in,
            busy, done, err};
  endfunction

  // Monitor: invariants every cycle plus in-order, cycle-exact event matching.
  always @(negedge clk) begin
    if (rst_n) begin
      ev_t obs;
      logic seen;
      if (!rf_write_en) check("rf_zero_when_idle", {56'd0, rf_waddr, rf_data_in}, 64'd0);
      check("done_err_exclusive", {63'd0, done & err}, 64'd0);
      if (!busy) check("idle_mem_addr_zero", {56'd0, mem_addr}, 64'd0);
      seen = 1'b1;
      obs  = '0;
      obs.cyc = cyc;
      if (mem_rd_en) begin
        obs.kind = K_RD; obs.addr = mem_addr;
      end else if (mem_wr_en) begin
        obs.kind = K_WR; obs.addr = mem_addr; obs.data = mem_wr_data;
      end else if (rf_write_en) begin
        obs.kind = K_RF; obs.addr = {4'd0, rf_waddr}; obs.data = rf_data_in;
      end else if (done) begin
        obs.kind = K_DONE;
      end else if (err) begin
        obs.kind = K_ERR;
      end else begin
        seen = 1'b0;
      end
      if (seen) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_event", {13'd0, obs}, 64'd0);
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          check("sb_event", {13'd0, obs}, {13'd0, e});
        end
      end
    end
  end

  initial begin
    int c;
    rst_n = 1'b0; start = 1'b0; is_store = 1'b0; ld_addr = '0; st_addr = '0; acc_in = '0;
    mem_rd_data = '0; mem_ready = 1'b0;

    // Reset state, with stimulus active to show it is ignored during reset.
    #12;
    start = 1'b1; mem_ready = 1'b1; ld_addr = 8'hFF;
    #1 check("reset_outputs_zero", {30'd0, all_outputs()}, 64'd0);
    repeat (2) @(posedge clk);
    #1 check("reset_outputs_zero_after_edges", {30'd0, all_outputs()}, 64'd0);
    next();
    start = 1'b0; mem_ready = 1'b0; ld_addr = '0;
    rst_n = 1'b1;
    next();
    next();

    // Minimum-latency load; MemReady high in IDLE and REQ must be ignored.
    c = int'(cyc);
    start = 1'b1; is_store = 1'b0; ld_addr = 8'h2A; st_addr = 8'h33; acc_in = 8'h77;
    mem_ready = 1'b1; mem_rd_data = 8'h11;
    push(K_RD, 8'h2A, 8'h00, c + 1);
    push(K_RF, 8'h0F, 8'h5C, c + 3);
    push(K_DONE, 8'h00, 8'h00, c + 4);
    next();
    start = 1'b0;
    check("load_busy_in_req", {63'd0, busy}, 64'd1);
    next();
    mem_rd_data = 8'h5C;
    next();
    mem_ready = 1'b0; mem_rd_data = 8'h00;
    next();
    check("load_busy_in_fin", {63'd0, busy}, 64'd1);
    next();
    check("load_idle_after_fin", {63'd0, busy}, 64'd0);
    next();

    // Store with MemReady after three WAIT cycles.
    c = int'(cyc);
    start = 1'b1; is_store = 1'b1; st_addr = 8'h80; ld_addr = 8'h13; acc_in = 8'hF1;
    push(K_WR, 8'h80, 8'hF1, c + 1);
    push(K_DONE, 8'h00, 8'h00, c + 6);
    next();
    start = 1'b0; is_store = 1'b0; acc_in = 8'h00;
    next();
    next();
    check("store_wait_addr_held", {56'd0, mem_addr}, 64'h80);
    check("store_wait_data_held", {56'd0, mem_wr_data}, 64'hF1);
    check("store_wait_strobes_low", {62'd0, mem_rd_en, mem_wr_en}, 64'd0);
    next();
    next();
    mem_ready = 1'b1;
    next();
    mem_ready = 1'b0;
    next();
    next();

    // Load timeout: 15 WAIT cycles, Err in FIN, Busy drops the next cycle.
    c = int'(cyc);
    start = 1'b1; is_store = 1'b0; ld_addr = 8'h3C;
    push(K_RD, 8'h3C, 8'h00, c + 1);
    push(K_ERR, 8'h00, 8'h00, c + 17);
    next();
    start = 1'b0;
    repeat (15) next();
    check("timeout_still_waiting", {62'd0, busy, err}, 64'd2);
    next();
    check("timeout_err_in_fin", {62'd0, busy, err}, 64'd3);
    next();
    check("timeout_busy_falls", {63'd0, busy}, 64'd0);
    next();

    // Back-to-back Start with IsStore toggling every cycle: accepted only in IDLE.
    begin
      int   idle_at;
      logic tog;
      idle_at = int'(cyc);
      tog = 1'b0;
      ld_addr = 8'h41; st_addr = 8'h42; acc_in = 8'h43;
      mem_ready = 1'b1; mem_rd_data = 8'hA5;
      for (int i = 0; i < 30; i++) begin
        start = 1'b1;
        is_store = tog;
        if (int'(cyc) == idle_at) begin
          c = idle_at;
          if (tog) begin
            push(K_WR, 8'h42, 8'h43, c + 1);
            push(K_DONE, 8'h00, 8'h00, c + 3);
            idle_at = c + 4;
          end else begin
            push(K_RD, 8'h41, 8'h00, c + 1);
            push(K_RF, 8'h0F, 8'hA5, c + 3);
            push(K_DONE, 8'h00, 8'h00, c + 4);
            idle_at = c + 5;
          end
        end
        tog = ~tog;
        next();
      end
      start = 1'b0;
      repeat (6) next();
      mem_ready = 1'b0;
      check("serial_queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    end
    next();

    // Reset asserted in WAIT of a load aborts it; a fresh load then runs normally.
    c = int'(cyc);
    start = 1'b1; is_store = 1'b0; ld_addr = 8'h5A;
    push(K_RD, 8'h5A, 8'h00, c + 1);
    next();
    start = 1'b0;
    next();
    next();
    #2 rst_n = 1'b0;
    #1 check("midop_reset_outputs_zero", {30'd0, all_outputs()}, 64'd0);
    @(posedge clk);
    #1 check("midop_reset_held", {30'd0, all_outputs()}, 64'd0);
    next();
    rst_n = 1'b1;
    c = int'(cyc);
    start = 1'b1; is_store = 1'b0; ld_addr = 8'h6B;
    push(K_RD, 8'h6B, 8'h00, c + 1);
    push(K_RF, 8'h0F, 8'h9E, c + 3);
    push(K_DONE, 8'h00, 8'h00, c + 4);
    next();
    start = 1'b0;
    next();
    mem_ready = 1'b1; mem_rd_data = 8'h9E;
    next();
    mem_ready = 1'b0; mem_rd_data = 8'h00;
    repeat (4) next();

    check("final_queue_drained", {32'd0, 32'(exp_q.size())}, 64'd0);
    check("final_idle", {63'd0, busy}, 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ld_st_unit.md
LD_ST_UNIT -- requirements
Module: ld_st_unit

Interface
REQ-001 Parameter W, default 8, SHALL set the data path and memory address width.
REQ-002 Parameter D, default 4, SHALL set the register-file address width; the accumulator is register 2**D-1.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of WAIT cycles before abort (range 1..255).
REQ-004 Clk  in  1  single clock; all state changes SHALL occur on posedge Clk.
REQ-005 Reset_n  in  1  SHALL be an asynchronous, active-low reset.
REQ-006 Start  in  1  SHALL request one memory operation (level, sampled in IDLE only).
REQ-007 IsStore  in  1  SHALL select the operation: 1 = store, 0 = load; sampled with Start.
REQ-008 LdAddr  in  W  SHALL be the load address, taken from load register R11.
REQ-009 StAddr  in  W  SHALL be the store address, taken from store register R12.
REQ-010 AccIn  in  W  SHALL be the store data, taken from the accumulator R15.
REQ-011 MemAddr  out  W  SHALL drive the data memory address.
REQ-012 MemRdEn / MemWrEn  out  1 each  SHALL be the read and write request strobes.
REQ-013 MemWrData  out  W  SHALL drive the store data.
REQ-014 MemRdData  in  W  SHALL carry the load data; it is valid when MemReady=1.
REQ-015 MemReady  in  1  SHALL be the memory completion acknowledge.
REQ-016 RfWriteEn  out  1, RfWaddr  out  D, RfDataIn  out  W  SHALL drive the register-file write port.
REQ-017 Busy  out  1, Done  out  1, Err  out  1  SHALL report status.

Function
REQ-018 The block SHALL implement the states IDLE, REQ, WAIT, WB and FIN.
REQ-019 In IDLE with Start=1:
- SHALL latch IsStore into the op register.
- SHALL latch LdAddr or StAddr (selected by IsStore) into the address register.
- SHALL latch AccIn into the data register.
- SHALL go to REQ.
REQ-020 In REQ, for exactly one cycle:
- MemRdEn (load) or MemWrEn (store) SHALL be 1.
- MemAddr SHALL equal the address register.
- MemWrData SHALL equal the data register.
- Next state SHALL be WAIT.
REQ-021 In WAIT, MemAddr and MemWrData SHALL be held and both strobes SHALL be 0; MemReady SHALL be ignored outside WAIT.
REQ-022 In WAIT with MemReady=1:
- Load: SHALL capture MemRdData and go to WB.
- Store: SHALL go to FIN.
REQ-023 In WAIT, a counter SHALL increment each cycle without MemReady; when the counter reaches TIMEOUT, the block SHALL go to FIN with the error flag set.
REQ-024 In WB, for exactly one cycle:
- RfWriteEn SHALL be 1.
- RfWaddr SHALL be 2**D-1.
- RfDataIn SHALL be the captured data.
- Next state SHALL be FIN.
REQ-025 In FIN, for one cycle:
- Done SHALL be 1 if there was no error.
- Err SHALL be 1 if the block timed out.
- Next state SHALL be IDLE.
- Done and Err SHALL never both be 1.
REQ-026 Busy SHALL be 1 in every state except IDLE; Start SHALL be ignored while Busy=1.
REQ-027 Minimum load latency (Start sampled in cycle 0, MemReady in first WAIT cycle):
- REQ in cycle 1, WAIT in cycle 2, WB in cycle 3, Done in cycle 4.
REQ-028 Minimum store latency on the same basis: Done in cycle 3.
REQ-029 A timeout SHALL NOT produce an RfWriteEn pulse.
REQ-030 RfWaddr and RfDataIn SHALL be 0 whenever RfWriteEn=0; MemAddr SHALL be 0 in IDLE.
REQ-031 Start held high in FIN SHALL be accepted only after the return to IDLE (one idle cycle minimum between operations).

Reset
REQ-032 While Reset_n=0, regardless of clock:
- State SHALL be IDLE.
- All outputs, counters and internal registers SHALL be 0.
REQ-033 Reset asserted mid-operation (any state) SHALL abort the operation with no RfWriteEn, Done or Err pulse.
REQ-034 After reset release, operation SHALL restart from IDLE on the next posedge.

Verification
REQ-035 Load: LdAddr=0x2A, MemReady 1 in first WAIT, MemRdData=0x5C -> MemRdEn cycle 1 with MemAddr=0x2A; RfWriteEn cycle 3 with RfWaddr=15, RfDataIn=0x5C; Done cycle 4.
REQ-036 Store: StAddr=0x80, AccIn=0xF1, MemReady after 3 WAIT cycles -> MemWrEn one cycle with MemAddr=0x80, MemWrData=0xF1; Done once; RfWriteEn never asserted.
REQ-037 Timeout: load, MemReady held 0 -> Err pulses after exactly 15 WAIT cycles; no RfWriteEn; Busy falls the next cycle.
REQ-038 Start=1 continuously with IsStore toggling each cycle -> operations are strictly serialized; each is sampled only in IDLE; one Done per operation.
REQ-039 Reset_n pulsed low in WAIT of a load -> all outputs 0 immediately; no Done, Err or RfWriteEn; a new load then completes normally.
REQ-040 MemReady=1 during REQ and during IDLE -> ignored; state sequence unchanged.
